gen_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one W-bit output datapath between N requesters. It grants at most one requester at a time, holds that grant while the requester keeps its request asserted, and forces release after MAX_HOLD cycles. While a grant is active, it forwards the owner's data to a registered output. It sits between the per-scope producers and the single downstream consumer of the shared bus.

---
 rtl/gen_rr_arbiter_if.sv | 13 +
 rtl/gen_rr_arbiter.sv | 86 ++++++++
 tb/tb_gen_rr_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/gen_rr_arbiter_if.sv
// gen_rr_arbiter_if: requester-side bundle and arbitrated output of the round-robin arbiter
interface gen_rr_arbiter_if #(parameter int N = 4, parameter int W = 2);
    localparam int OW = N > 1 ? $clog2(N) : 1;
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   gnt;
    logic           busy;
    logic [OW-1:0]  owner;
    logic [W-1:0]   dout;
    logic           dout_valid;
    modport master (output req, data_in, input gnt, busy, owner, dout, dout_valid);
    modport slave (input req, data_in, output gnt, busy, owner, dout, dout_valid);
endinterface

// File: rtl/gen_rr_arbiter.sv
// gen_rr_arbiter: round-robin arbiter with a per-ownership hold limit,
// forwarding the owner's data to a registered output.
module gen_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2,
    parameter int MAX_HOLD = 8
) (
    input logic clk,
    input logic rst_n,
    gen_rr_arbiter_if.slave bus
);
    localparam int OW = N > 1 ? $clog2(N) : 1;
    localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_n;
    logic [OW-1:0] ptr, ptr_n, owner, owner_n, sel, idx, nxt;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [N-1:0] gnt, gnt_n;
    logic [W-1:0] dout, dout_n;
    logic dv, dv_n;
    // Walk offsets high to low so the requester closest above ptr wins.
    always_comb begin
        sel = ptr;
        idx = ptr;
        for (int i = N - 1; i >= 0; i--) begin
            idx = OW'((int'(ptr) + i) % N);
            if (bus.req[idx]) sel = idx;
        end
    end
    assign nxt = owner == OW'(N - 1) ? '0 : owner + 1'b1;
    always_comb begin
        state_n = state;
        ptr_n = ptr;
        owner_n = owner;
        hold_n = hold_cnt;
        gnt_n = gnt;
        dout_n = dout;
        dv_n = 1'b0;
        if (state == IDLE) begin
            if (|bus.req) begin
                state_n = GRANT;
                gnt_n = N'(1) << sel;
                owner_n = sel;
                hold_n = '0;
            end
        end else if (bus.req[owner]) begin
            dout_n = bus.data_in[int'(owner) * W +: W];
            dv_n = 1'b1;
            if (hold_cnt == HW'(MAX_HOLD - 1)) begin
                state_n = IDLE;
                gnt_n = '0;
                ptr_n = nxt;
            end else begin
                hold_n = hold_cnt + 1'b1;
            end
        end else begin
            state_n = IDLE;
            gnt_n = '0;
            ptr_n = nxt;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= '0;
            owner <= '0;
            hold_cnt <= '0;
            gnt <= '0;
            dout <= '0;
            dv <= 1'b0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            owner <= owner_n;
            hold_cnt <= hold_n;
            gnt <= gnt_n;
            dout <= dout_n;
            dv <= dv_n;
        end
    end
    assign bus.gnt = gnt;
    assign bus.busy = state == GRANT;
    assign bus.owner = owner;
    assign bus.dout = dout;
    assign bus.dout_valid = dv;
endmodule

// File: tb/tb_gen_rr_arbiter.sv
// tb_gen_rr_arbiter: scoreboard bench for a 4-way/hold-8 arbiter and a 3-way/hold-1 arbiter.
module tb_gen_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int oq0[$], dq0[$], oq1[$], dq1[$];
    int pg0 = 0, po0 = 0, len0 = 0, pg1 = 0, po1 = 0, len1 = 0;
    always #5 clk = ~clk;
    gen_rr_arbiter_if #(.N(4), .W(2)) b0();
    gen_rr_arbiter_if #(.N(3), .W(2)) b1();
    gen_rr_arbiter #(.N(4), .W(2), .MAX_HOLD(8)) u0(.clk(clk), .rst_n(rst_n), .bus(b0));
    gen_rr_arbiter #(.N(3), .W(2), .MAX_HOLD(1)) u1(.clk(clk), .rst_n(rst_n), .bus(b1));
    task automatic chk(input string n, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, got, want);
        end
    endtask
    // Ownership record: grant vector, owner index, grant length in cycles.
    function automatic int own(input int g, input int o, input int l);
        return (g << 16) | (o << 8) | l;
    endfunction
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic exp0(input int o, input int l, input int d, input int nd);
        oq0.push_back(own(1 << o, o, l));
        repeat (nd) dq0.push_back(d);
    endtask
    task automatic exp1(input int o, input int l, input int d, input int nd);
        oq1.push_back(own(1 << o, o, l));
        repeat (nd) dq1.push_back(d);
    endtask
    always @(negedge clk) begin
        if (!rst_n) begin
            pg0 = 0;
            len0 = 0;
        end else begin
            if (b0.dout_valid) begin
                if (dq0.size() == 0) chk("dout0_extra", int'(b0.dout), -1);
                else chk("dout0", int'(b0.dout), dq0.pop_front());
            end
            if (pg0 != 0 && int'(b0.gnt) != pg0) begin
                if (oq0.size() == 0) chk("own0_extra", pg0, -1);
                else chk("own0", own(pg0, po0, len0), oq0.pop_front());
                chk("gap0", int'(b0.gnt), 0);
            end
            if (b0.gnt != 0 && int'(b0.gnt) == pg0) len0++;
            else if (b0.gnt != 0) begin
                len0 = 1;
                po0 = int'(b0.owner);
            end
            pg0 = int'(b0.gnt);
        end
    end
    always @(negedge clk) begin
        if (!rst_n) begin
            pg1 = 0;
            len1 = 0;
        end else begin
            if (b1.dout_valid) begin
                if (dq1.size() == 0) chk("dout1_extra", int'(b1.dout), -1);
                else chk("dout1", int'(b1.dout), dq1.pop_front());
            end
            if (pg1 != 0 && int'(b1.gnt) != pg1) begin
                if (oq1.size() == 0) chk("own1_extra", pg1, -1);
                else chk("own1", own(pg1, po1, len1), oq1.pop_front());
                chk("gap1", int'(b1.gnt), 0);
            end
            if (b1.gnt != 0 && int'(b1.gnt) == pg1) len1++;
            else if (b1.gnt != 0) begin
                len1 = 1;
                po1 = int'(b1.owner);
            end
            pg1 = int'(b1.gnt);
        end
    end
    initial begin
        b0.req = 4'b1111;
        b0.data_in = {2'd3, 2'd2, 2'd1, 2'd0};
        b1.req = 3'b000;
        b1.data_in = {2'd2, 2'd1, 2'd3};
        tick(3);
        chk("rst_gnt", int'(b0.gnt), 0);
        chk("rst_busy", int'(b0.busy), 0);
        chk("rst_owner", int'(b0.owner), 0);
        chk("rst_dout", int'(b0.dout), 0);
        chk("rst_dv", int'(b0.dout_valid), 0);
        rst_n = 1'b1;
        b0.req = 4'b0001;
        exp0(0, 3, 0, 2);
        tick(1);
        chk("first_gnt", int'(b0.gnt), 1);
        chk("first_busy", int'(b0.busy), 1);
        tick(2);
        b0.req = 4'b0000;
        tick(2);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        b0.req = 4'b1111;
        for (int k = 0; k < 5; k++) exp0(k % 4, 8, k % 4, 8);
        tick(45);
        b0.req = 4'b0000;
        tick(2);
        b0.req = 4'b0100;
        exp0(2, 4, 2, 3);
        tick(4);
        b0.req = 4'b0000;
        tick(2);
        b0.req = 4'b0101;
        exp0(0, 2, 0, 1);
        exp0(2, 1, 2, 0);
        tick(2);
        b0.req = 4'b0100;
        tick(2);
        b0.req = 4'b0000;
        tick(2);
        b0.req = 4'b0010;
        exp0(1, 4, 1, 3);
        tick(2);
        b0.req = 4'b1010;
        tick(2);
        chk("contend_gnt", int'(b0.gnt), 2);
        b0.req = 4'b1000;
        tick(2);
        chk("gnt3", int'(b0.gnt), 8);
        // Only the first capture of requester 3 is seen; reset lands before the second is sampled.
        dq0.push_back(3);
        tick(2);
        chk("pre_rst_dv", int'(b0.dout_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_gnt", int'(b0.gnt), 0);
        chk("async_busy", int'(b0.busy), 0);
        chk("async_dv", int'(b0.dout_valid), 0);
        chk("async_owner", int'(b0.owner), 0);
        chk("async_dout", int'(b0.dout), 0);
        #2;
        rst_n = 1'b1;
        b0.req = 4'b1010;
        exp0(1, 1, 1, 0);
        exp0(3, 1, 3, 0);
        tick(1);
        chk("post_rst_gnt", int'(b0.gnt), 2);
        b0.req = 4'b1000;
        tick(2);
        b0.req = 4'b0000;
        tick(2);
        b1.req = 3'b111;
        exp1(0, 1, 3, 1);
        exp1(1, 1, 1, 1);
        exp1(2, 1, 2, 1);
        exp1(0, 1, 3, 1);
        tick(8);
        b1.req = 3'b000;
        tick(2);
        chk("owner1_wrap", int'(b1.owner), 0);
        chk("oq0_left", oq0.size(), 0);
        chk("dq0_left", dq0.size(), 0);
        chk("oq1_left", oq1.size(), 0);
        chk("dq1_left", dq1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
